// File: rtl/baud_frac_gen.sv
// Fractional baud-rate tick generator: emits oversample and bit ticks from a
// divisor of div_int + div_frac/2^FRAC_W system clocks per oversample tick.
// Optional feature macro: BAUD_FRAC_GEN_FRAC_EN enables the fractional
// accumulator; when undefined every period is exactly div_int clocks.
module baud_frac_gen #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 8,
  localparam int unsigned PH_W      = $clog2(OVERSAMPLE)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_cfg_load,
  input  logic [DIV_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  input  logic              i_resync,
  output logic              o_os_tick,
  output logic              o_bit_tick,
  output logic [PH_W-1:0]   o_phase,
  output logic              o_cfg_err
);

  localparam int unsigned CNT_W   = DIV_W + 1;
  localparam int unsigned RST_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);

  // state registers
  logic [CNT_W-1:0]  cnt_q;
  logic [DIV_W-1:0]  shd_int_q;
  logic [DIV_W-1:0]  pend_int_q;
  logic              pend_vld_q;
  logic              pend_arm_q;
  logic              run_q;

  // next-state values
  logic [CNT_W-1:0]  cnt_d;
  logic [DIV_W-1:0]  shd_int_d;
  logic [DIV_W-1:0]  pend_int_d;
  logic              pend_vld_d;
  logic              pend_arm_d;
  logic              run_d;
  logic              os_tick_d;
  logic              bit_tick_d;
  logic [PH_W-1:0]   phase_d;
  logic              cfg_err_d;

  // datapath helpers
  logic              carry_c;
  logic [CNT_W-1:0]  period_len_c;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic              period_end_c;
  logic              cfg_ok_c;
  logic              load_ok_c;
  logic              direct_load_c;

`ifdef BAUD_FRAC_GEN_FRAC_EN
  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W-1:0] acc_d;
  logic [FRAC_W-1:0] shd_frac_q;
  logic [FRAC_W-1:0] shd_frac_d;
  logic [FRAC_W-1:0] pend_frac_q;
  logic [FRAC_W-1:0] pend_frac_d;
  logic [FRAC_W:0]   acc_sum_c;

  // fractional accumulate: carry stretches the current period by one clock
  always_comb begin
    acc_sum_c = {1'b0, acc_q} + {1'b0, shd_frac_q};
    carry_c   = acc_sum_c[FRAC_W];
  end
`else
  logic unused_div_frac;

  // fractional input has no effect in the integer-only build
  assign unused_div_frac = ^i_div_frac;
  assign carry_c         = 1'b0;
`endif

  // period length and end-of-period detect against the active shadow divisor
  always_comb begin
    period_len_c  = CNT_W'(shd_int_q) + CNT_W'(carry_c);
    cnt_inc_c     = cnt_q + CNT_W'(1);
    period_end_c  = (cnt_inc_c >= period_len_c);
    cfg_ok_c      = (i_div_int >= DIV_W'(2));
    load_ok_c     = i_cfg_load && cfg_ok_c;
    // idle, first enabled edge, or restart: new divisor can take effect at once
    direct_load_c = !i_enable || !run_q || i_resync;
  end

  // next-state logic for counter, phase, ticks and divisor shadowing
  always_comb begin
    cnt_d      = cnt_q;
    shd_int_d  = shd_int_q;
    pend_int_d = pend_int_q;
    pend_vld_d = pend_vld_q;
    pend_arm_d = pend_arm_q;
    run_d      = i_enable;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    phase_d    = o_phase;
    cfg_err_d  = i_cfg_load && !cfg_ok_c;
`ifdef BAUD_FRAC_GEN_FRAC_EN
    acc_d       = acc_q;
    shd_frac_d  = shd_frac_q;
    pend_frac_d = pend_frac_q;
`endif

    // a pending load waits for the first tick after it before arming
    if (pend_vld_q && o_os_tick && i_enable) begin
      pend_arm_d = 1'b1;
    end

    if (!i_enable || i_resync) begin
      cnt_d   = '0;
      phase_d = '0;
`ifdef BAUD_FRAC_GEN_FRAC_EN
      acc_d   = '0;
`endif
    end else if (period_end_c) begin
      cnt_d      = '0;
      os_tick_d  = 1'b1;
      phase_d    = o_phase + PH_W'(1);
      bit_tick_d = (o_phase == PH_W'(OVERSAMPLE - 1));
`ifdef BAUD_FRAC_GEN_FRAC_EN
      acc_d      = acc_sum_c[FRAC_W-1:0];
`endif
      // armed pending divisor governs the period starting after this edge
      if (pend_vld_q && pend_arm_q) begin
        shd_int_d  = pend_int_q;
        pend_vld_d = 1'b0;
        pend_arm_d = 1'b0;
`ifdef BAUD_FRAC_GEN_FRAC_EN
        shd_frac_d = pend_frac_q;
`endif
      end
    end else begin
      cnt_d = cnt_inc_c;
    end

    // accepted loads either update the shadow now or queue as pending
    if (load_ok_c) begin
      if (direct_load_c) begin
        shd_int_d  = i_div_int;
        pend_vld_d = 1'b0;
        pend_arm_d = 1'b0;
`ifdef BAUD_FRAC_GEN_FRAC_EN
        shd_frac_d = i_div_frac;
`endif
      end else begin
        pend_int_d = i_div_int;
        pend_vld_d = 1'b1;
        pend_arm_d = 1'b0;
`ifdef BAUD_FRAC_GEN_FRAC_EN
        pend_frac_d = i_div_frac;
`endif
      end
    end
  end

  // state register with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q      <= '0;
      shd_int_q  <= DIV_W'(RST_DIV);
      pend_int_q <= '0;
      pend_vld_q <= 1'b0;
      pend_arm_q <= 1'b0;
      run_q      <= 1'b0;
      o_os_tick  <= 1'b0;
      o_bit_tick <= 1'b0;
      o_phase    <= '0;
      o_cfg_err  <= 1'b0;
`ifdef BAUD_FRAC_GEN_FRAC_EN
      acc_q       <= '0;
      shd_frac_q  <= '0;
      pend_frac_q <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      shd_int_q  <= shd_int_d;
      pend_int_q <= pend_int_d;
      pend_vld_q <= pend_vld_d;
      pend_arm_q <= pend_arm_d;
      run_q      <= run_d;
      o_os_tick  <= os_tick_d;
      o_bit_tick <= bit_tick_d;
      o_phase    <= phase_d;
      o_cfg_err  <= cfg_err_d;
`ifdef BAUD_FRAC_GEN_FRAC_EN
      acc_q       <= acc_d;
      shd_frac_q  <= shd_frac_d;
      pend_frac_q <= pend_frac_d;
`endif
    end
  end

endmodule

// File: tb/tb_baud_frac_gen.sv
// Directed bench for baud_frac_gen with default parameters (divisor 54).
// Expectations for the fractional load follow BAUD_FRAC_GEN_FRAC_EN.
module tb_baud_frac_gen;

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned PH_W   = 4;

  logic              i_clk;
  logic              i_rst;
  logic              i_enable;
  logic              i_cfg_load;
  logic [DIV_W-1:0]  i_div_int;
  logic [FRAC_W-1:0] i_div_frac;
  logic              i_resync;
  logic              o_os_tick;
  logic              o_bit_tick;
  logic [PH_W-1:0]   o_phase;
  logic              o_cfg_err;

  int checks = 0;
  int errors = 0;

  baud_frac_gen dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_enable   (i_enable),
    .i_cfg_load (i_cfg_load),
    .i_div_int  (i_div_int),
    .i_div_frac (i_div_frac),
    .i_resync   (i_resync),
    .o_os_tick  (o_os_tick),
    .o_bit_tick (o_bit_tick),
    .o_phase    (o_phase),
    .o_cfg_err  (o_cfg_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // negedges until o_os_tick is seen; -1 on timeout
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (o_os_tick !== 1'b1 && n < budget);
    if (o_os_tick !== 1'b1) n = -1;
  endtask

  // negedges until o_bit_tick is seen, also counting oversample ticks
  task automatic wait_bit(input int budget, output int n, output int nt);
    n  = 0;
    nt = 0;
    do begin
      @(negedge i_clk);
      n++;
      if (o_os_tick === 1'b1) nt++;
    end while (o_bit_tick !== 1'b1 && n < budget);
    if (o_bit_tick !== 1'b1) n = -1;
  endtask

  function automatic int exp_frac_period(input int idx);
`ifdef BAUD_FRAC_GEN_FRAC_EN
    return (idx % 2 == 1) ? 5 : 4;
`else
    return 4 + 0 * idx;
`endif
  endfunction

  initial begin
    int n;
    int nt;
    int total;
    int cnt;

    i_rst      = 1'b1;
    i_enable   = 1'b0;
    i_cfg_load = 1'b0;
    i_div_int  = '0;
    i_div_frac = '0;
    i_resync   = 1'b0;

    // reset values
    repeat (3) @(negedge i_clk);
    chk("rst_os_tick", int'(o_os_tick), 0);
    chk("rst_bit_tick", int'(o_bit_tick), 0);
    chk("rst_phase", int'(o_phase), 0);
    chk("rst_cfg_err", int'(o_cfg_err), 0);

    // enable with reset divisor 54; bit tick every 864 clocks
    i_rst    = 1'b0;
    i_enable = 1'b1;
    wait_tick(100, n);
    chk("first_tick_54", n, 54);
    chk("phase_after_first", int'(o_phase), 1);
    wait_bit(2000, n, nt);
    chk("first_bit_tick", n, 810);
    chk("first_bit_os_ticks", nt, 15);
    chk("bit_tick_phase", int'(o_phase), 0);
    chk("bit_with_os_tick", int'(o_os_tick), 1);
    wait_bit(2000, n, nt);
    chk("bit_period_864", n, 864);
    chk("bit_period_os_ticks", nt, 16);
    wait_tick(100, n);
    chk("tick_after_bit", n, 54);

    // disable clears phase and stops ticks
    i_enable = 1'b0;
    @(negedge i_clk);
    chk("dis_phase", int'(o_phase), 0);
    chk("dis_tick", int'(o_os_tick), 0);
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge i_clk);
      if (o_os_tick === 1'b1 || o_bit_tick === 1'b1) cnt++;
    end
    chk("dis_no_ticks", cnt, 0);

    // load 4 + 0x80/256 while disabled, then run 32 oversample ticks
    i_cfg_load = 1'b1;
    i_div_int  = 16'd4;
    i_div_frac = 8'h80;
    @(negedge i_clk);
    i_cfg_load = 1'b0;
    chk("load4_no_err", int'(o_cfg_err), 0);
    i_enable = 1'b1;
    total = 0;
    for (int i = 0; i < 32; i++) begin
      wait_tick(20, n);
      if (i < 4) chk($sformatf("frac_period_%0d", i), n, exp_frac_period(i));
      total += n;
    end
`ifdef BAUD_FRAC_GEN_FRAC_EN
    chk("frac_32_ticks", total, 144);
`else
    chk("frac_32_ticks", total, 128);
`endif

    // load together with rising enable governs the first period
    i_enable = 1'b0;
    @(negedge i_clk);
    i_enable   = 1'b1;
    i_cfg_load = 1'b1;
    i_div_int  = 16'd6;
    i_div_frac = 8'h00;
    @(negedge i_clk);
    i_cfg_load = 1'b0;
    wait_tick(20, n);
    chk("rise_load_6", n + 1, 6);

    // illegal load (div_int=1) while running: error pulse, divisor kept
    repeat (2) @(negedge i_clk);
    i_cfg_load = 1'b1;
    i_div_int  = 16'd1;
    i_div_frac = 8'hff;
    @(negedge i_clk);
    i_cfg_load = 1'b0;
    chk("cfg_err_pulse", int'(o_cfg_err), 1);
    @(negedge i_clk);
    chk("cfg_err_single", int'(o_cfg_err), 0);
    wait_tick(20, n);
    chk("bad_load_rem", n, 2);
    wait_tick(20, n);
    chk("bad_load_p1", n, 6);
    wait_tick(20, n);
    chk("bad_load_p2", n, 6);

    // divisor 10, resync 3 clocks after a tick
    i_enable   = 1'b0;
    i_cfg_load = 1'b1;
    i_div_int  = 16'd10;
    @(negedge i_clk);
    i_cfg_load = 1'b0;
    i_enable   = 1'b1;
    wait_tick(30, n);
    chk("div10_first", n, 10);
    repeat (2) @(negedge i_clk);
    i_resync = 1'b1;
    @(negedge i_clk);
    i_resync = 1'b0;
    chk("resync_no_tick", int'(o_os_tick), 0);
    chk("resync_phase0", int'(o_phase), 0);
    wait_tick(30, n);
    chk("resync_next_10", n, 10);
    chk("resync_phase1", int'(o_phase), 1);

    // resync on the edge that would have produced a tick
    repeat (9) @(negedge i_clk);
    i_resync = 1'b1;
    @(negedge i_clk);
    i_resync = 1'b0;
    chk("resync_suppress", int'(o_os_tick), 0);
    wait_tick(30, n);
    chk("resync2_next_10", n, 10);
    chk("resync2_phase1", int'(o_phase), 1);

    // divisor 8, load 12 mid-period: 8, 8, then 12
    i_enable   = 1'b0;
    i_cfg_load = 1'b1;
    i_div_int  = 16'd8;
    @(negedge i_clk);
    i_cfg_load = 1'b0;
    i_enable   = 1'b1;
    wait_tick(30, n);
    chk("div8_first", n, 8);
    repeat (3) @(negedge i_clk);
    i_cfg_load = 1'b1;
    i_div_int  = 16'd12;
    @(negedge i_clk);
    i_cfg_load = 1'b0;
    wait_tick(30, n);
    chk("pend_cur_rem", n, 4);
    wait_tick(30, n);
    chk("pend_next_8", n, 8);
    wait_tick(30, n);
    chk("pend_new_12a", n, 12);
    wait_tick(30, n);
    chk("pend_new_12b", n, 12);

    // simultaneous resync and load: restarted period uses the new divisor
    repeat (2) @(negedge i_clk);
    i_resync   = 1'b1;
    i_cfg_load = 1'b1;
    i_div_int  = 16'd5;
    @(negedge i_clk);
    i_resync   = 1'b0;
    i_cfg_load = 1'b0;
    wait_tick(30, n);
    chk("resync_load_5", n, 5);
    chk("resync_load_phase", int'(o_phase), 1);
    wait_tick(30, n);
    chk("resync_load_next", n, 5);

    // reset mid-period aborts the period and restores divisor 54
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("midrst_os_tick", int'(o_os_tick), 0);
    chk("midrst_phase", int'(o_phase), 0);
    repeat (2) @(negedge i_clk);
    chk("midrst_held_tick", int'(o_os_tick), 0);
    i_rst = 1'b0;
    wait_tick(100, n);
    chk("post_rst_54", n, 54);
    chk("post_rst_phase", int'(o_phase), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/baud_frac_gen.md
BAUD_FRAC_GEN -- requirements
Module: baud_frac_gen

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, baud rate used to derive the reset divisor.
REQ-003 Parameter OVERSAMPLE, default 16, oversample ticks per bit; legal values are powers of two from 2 to 64.
REQ-004 Parameter DIV_W, default 16, width of the integer divisor.
REQ-005 Parameter FRAC_W, default 8, width of the fractional divisor.
REQ-006 i_clk  in  1  system clock; reset is asynchronous and active-high.
REQ-007 i_rst  in  1  asynchronous active-high reset.
REQ-008 i_enable  in  1  tick generation enable, level-sensitive.
REQ-009 i_cfg_load  in  1  single-cycle strobe that captures the divisor inputs.
REQ-010 i_div_int  in  DIV_W  integer clocks per oversample tick.
REQ-011 i_div_frac  in  FRAC_W  fractional clocks per oversample tick, in units of 2^-FRAC_W.
REQ-012 i_resync  in  1  phase restart strobe, for receiver start-bit alignment.
REQ-013 o_os_tick  out  1  oversample tick, single-cycle pulse.
REQ-014 o_bit_tick  out  1  bit tick, single-cycle pulse.
REQ-015 o_phase  out  log2(OVERSAMPLE)  count of oversample ticks within the current bit.
REQ-016 o_cfg_err  out  1  single-cycle pulse flagging an illegal divisor load.

Function
REQ-017 Active divisor D = div_int + div_frac/2^FRAC_W, held in shadow registers.
- Each oversample period lasts div_int clocks, or div_int+1 clocks when the frac accumulator carries.
- Accumulator update per period: acc <= (acc + div_frac) mod 2^FRAC_W; carry = overflow of that add.
REQ-018 With i_enable high from edge 0, o_os_tick is asserted for exactly the single cycle following the first period's final edge.
- First period is div_int (+carry) edges.
- No gaps or double pulses between periods.
REQ-019 o_phase increments mod OVERSAMPLE in the same cycle o_os_tick is asserted.
REQ-020 o_bit_tick is asserted together with the o_os_tick that wraps o_phase from OVERSAMPLE-1 to 0.
REQ-021 i_cfg_load while i_enable is low updates the shadow registers on the next edge.
REQ-022 i_cfg_load while running holds the new values pending; they apply from the period that begins after the next o_os_tick.
- A second load before then overwrites the pending values.
REQ-023 i_cfg_load with i_div_int < 2 is rejected:
- shadow registers keep their old values;
- o_cfg_err pulses one cycle.
REQ-024 i_cfg_load together with a rising i_enable: the new divisor governs the first period.
REQ-025 i_enable low clears the cycle counter, accumulator and o_phase on the next edge; shadow registers are retained.
- o_os_tick and o_bit_tick are low while disabled.
REQ-026 i_resync while enabled clears the cycle counter, accumulator and o_phase, and suppresses any tick in that cycle.
- Next o_os_tick follows a full div_int-clock period.
- i_resync is ignored while disabled.
REQ-027 Simultaneous i_resync and i_cfg_load while running: both the pending config and the restart take effect, and the restarted period uses the new divisor.
REQ-028 The cycle counter is DIV_W+1 bits wide and never wraps; all outputs are registered.

Reset
REQ-029 Asynchronous reset values:
- o_os_tick, o_bit_tick, o_cfg_err, o_phase, counter, accumulator and pending flag = 0;
- shadow div_int = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) (integer), shadow div_frac = 0.
REQ-030 Reset asserted mid-period aborts the period with no partial tick; ticks resume per REQ-018 after release.

Configuration
REQ-031 Macro BAUD_FRAC_GEN_FRAC_EN defined: the fractional accumulator is implemented as in REQ-017.
REQ-032 Macro BAUD_FRAC_GEN_FRAC_EN undefined:
- i_div_frac is ignored and no accumulator exists;
- every period is exactly div_int clocks;
- all other behaviour is unchanged.

Verification
REQ-033 Reset, enable, no load:
- expect the first o_os_tick after 54 edges (100 MHz, 115200 baud, OVERSAMPLE=16 gives divisor 54);
- expect o_bit_tick every 864 clocks.
REQ-034 Load div_int=4, div_frac=0x80 (FRAC_W=8), FRAC_EN defined:
- expect periods alternating 4,5,4,5;
- expect 144 clocks per 32 oversample ticks.
REQ-035 Same load with FRAC_EN undefined: expect every period to be 4 clocks.
REQ-036 Load div_int=1 while running with divisor 6: expect o_cfg_err to pulse one cycle and periods to stay at 6.
REQ-037 Running with divisor 10, pulse i_resync 3 clocks after a tick:
- expect no tick in that cycle;
- expect the next tick 10 clocks later and o_phase = 1.
REQ-038 Running with divisor 8, load 12 mid-period:
- expect the current and next periods to be 8;
- expect subsequent periods to be 12.
